// File: rtl/acorn128_sched.sv
// Round-robin scheduler that shares one acorn128 core between two requesters.
// Optional watchdog: define ACORN_SCHED_TIMEOUT_EN to compile in the RUN timeout.
module acorn128_sched #(
    parameter int unsigned TIMEOUT_CYCLES = 4000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid_0,
    input  logic         req_valid_1,
    output logic         req_ready_0,
    output logic         req_ready_1,
    input  logic         req_encrypt_0,
    input  logic         req_encrypt_1,
    input  logic [127:0] req_key_0,
    input  logic [127:0] req_key_1,
    input  logic [127:0] req_iv_0,
    input  logic [127:0] req_iv_1,
    input  logic [127:0] req_data_0,
    input  logic [127:0] req_data_1,
    input  logic [127:0] req_ad_0,
    input  logic [127:0] req_ad_1,
    input  logic [63:0]  req_len_0,
    input  logic [63:0]  req_len_1,
    output logic         rsp_valid_0,
    output logic         rsp_valid_1,
    input  logic         rsp_ready_0,
    input  logic         rsp_ready_1,
    output logic [127:0] rsp_data,
    output logic [127:0] rsp_tag,
    output logic         rsp_err,
    output logic         core_start,
    output logic         core_encrypt,
    output logic [127:0] core_key,
    output logic [127:0] core_iv,
    output logic [127:0] core_plaintext,
    output logic [127:0] core_ciphertext,
    output logic [127:0] core_ad,
    output logic [63:0]  core_len,
    input  logic [127:0] core_ciphertext_in,
    input  logic [127:0] core_plaintext_in,
    input  logic [127:0] core_tag_in,
    input  logic         core_ready_in,
    output logic         busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_RESP} state_e;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("acorn128_sched: TIMEOUT_CYCLES out of range 1..65535");
    end

    state_e       state_q, state_d;
    logic         last_q, last_d;
    logic         g_q, g_d;
    logic         drain_q, drain_d;
    logic         start_q, start_d;
    logic         busy_q, busy_d;
    logic         vld0_q, vld0_d, vld1_q, vld1_d;
    logic         enc_q, enc_d;
    logic [127:0] key_q, key_d, iv_q, iv_d, dat_q, dat_d, ad_q, ad_d;
    logic [63:0]  len_q, len_d;
    logic [127:0] rdat_q, rdat_d, rtag_q, rtag_d;
    logic         rerr_q, rerr_d;
    logic         gnt_any, gnt_idx, timeout;

`ifdef ACORN_SCHED_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;

    assign timeout = (cnt_q == TO_LAST);

    // Cleared while idle so every job starts from zero; saturates instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE)
            cnt_d = '0;
        else if (state_q == S_RUN && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // On a tie the requester that did not win last time gets the grant.
    assign gnt_any     = req_valid_0 | req_valid_1;
    assign gnt_idx     = (req_valid_0 & req_valid_1) ? ~last_q : req_valid_1;
    assign req_ready_0 = (state_q == S_IDLE) & req_valid_0 & ~gnt_idx;
    assign req_ready_1 = (state_q == S_IDLE) & req_valid_1 &  gnt_idx;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        g_d     = g_q;
        drain_d = drain_q;
        start_d = start_q;
        vld0_d  = vld0_q;
        vld1_d  = vld1_q;
        enc_d   = enc_q;
        key_d   = key_q;
        iv_d    = iv_q;
        dat_d   = dat_q;
        ad_d    = ad_q;
        len_d   = len_q;
        rdat_d  = rdat_q;
        rtag_d  = rtag_q;
        rerr_d  = rerr_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    g_d     = gnt_idx;
                    last_d  = gnt_idx;
                    enc_d   = gnt_idx ? req_encrypt_1 : req_encrypt_0;
                    key_d   = gnt_idx ? req_key_1     : req_key_0;
                    iv_d    = gnt_idx ? req_iv_1      : req_iv_0;
                    dat_d   = gnt_idx ? req_data_1    : req_data_0;
                    ad_d    = gnt_idx ? req_ad_1      : req_ad_0;
                    len_d   = gnt_idx ? req_len_1     : req_len_0;
                    start_d = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (core_ready_in) begin
                    rdat_d  = enc_q ? core_ciphertext_in : core_plaintext_in;
                    rtag_d  = core_tag_in;
                    rerr_d  = 1'b0;
                    start_d = 1'b0;
                    drain_d = 1'b0;
                    state_d = S_DRAIN;
                end else if (timeout) begin
                    rdat_d  = '0;
                    rtag_d  = '0;
                    rerr_d  = 1'b1;
                    start_d = 1'b0;
                    drain_d = 1'b0;
                    state_d = S_DRAIN;
                end
            end
            // Two cycles of start low let the core fall back to waiting and drop ready.
            S_DRAIN: begin
                if (drain_q) begin
                    vld0_d  = ~g_q;
                    vld1_d  =  g_q;
                    state_d = S_RESP;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_RESP: begin
                if (g_q ? rsp_ready_1 : rsp_ready_0) begin
                    vld0_d  = 1'b0;
                    vld1_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            g_q     <= 1'b0;
            drain_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
            enc_q   <= 1'b0;
            key_q   <= '0;
            iv_q    <= '0;
            dat_q   <= '0;
            ad_q    <= '0;
            len_q   <= '0;
            rdat_q  <= '0;
            rtag_q  <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            g_q     <= g_d;
            drain_q <= drain_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            vld0_q  <= vld0_d;
            vld1_q  <= vld1_d;
            enc_q   <= enc_d;
            key_q   <= key_d;
            iv_q    <= iv_d;
            dat_q   <= dat_d;
            ad_q    <= ad_d;
            len_q   <= len_d;
            rdat_q  <= rdat_d;
            rtag_q  <= rtag_d;
            rerr_q  <= rerr_d;
        end
    end

    assign core_start      = start_q;
    assign core_encrypt    = enc_q;
    assign core_key        = key_q;
    assign core_iv         = iv_q;
    assign core_plaintext  = dat_q;
    assign core_ciphertext = dat_q;
    assign core_ad         = ad_q;
    assign core_len        = len_q;
    assign rsp_valid_0     = vld0_q;
    assign rsp_valid_1     = vld1_q;
    assign rsp_data        = rdat_q;
    assign rsp_tag         = rtag_q;
    assign rsp_err         = rerr_q;
    assign busy            = busy_q;

endmodule

// File: doc/acorn128_sched.md
# acorn128_sched

Two-requester scheduler that shares one `acorn128_top` core. It arbitrates round-robin between requesters and latches the winner's operands. It holds the core's `start_in` high for the whole job, captures the result when the core raises `ready_out`, then drops `start_in` so the core returns to its waiting phase. The result is returned to the winning requester over a valid/ready response channel. It sits between the system bus adapters and the core, and owns the core's `start_in` and all of the core's operand inputs.

## Interface
- `TIMEOUT_CYCLES`, default 4000: maximum cycles spent in RUN before the job is aborted. Legal range 1..65535.
- `clk` in 1: single clock, shared with the core.
- `rst` in 1: reset, synchronous and active-high; one clock domain. Does not drive the core's `rst`.
- `req_valid_0`/`req_valid_1` in 1: request pending.
- `req_ready_0`/`req_ready_1` out 1: request accepted this cycle when `valid & ready`.
- `req_encrypt_0`/`_1` in 1: 1 = encrypt, 0 = decrypt.
- `req_key_0`/`_1`, `req_iv_0`/`_1`, `req_data_0`/`_1`, `req_ad_0`/`_1` in 128 each: key, IV, plaintext-or-ciphertext, associated data.
- `req_len_0`/`_1` in 64: data length.
- `rsp_valid_0`/`_1` out 1: result available.
- `rsp_ready_0`/`_1` in 1: result consumed.
- `rsp_data` out 128: ciphertext (encrypt) or plaintext (decrypt).
- `rsp_tag` out 128: authentication tag.
- `rsp_err` out 1: job aborted by timeout.
- `core_start` out 1; `core_encrypt` out 1; `core_key`, `core_iv`, `core_plaintext`, `core_ciphertext`, `core_ad` out 128; `core_len` out 64: core operand drive.
- `core_ciphertext_in`, `core_plaintext_in`, `core_tag_in` in 128; `core_ready_in` in 1: core results.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, RUN, DRAIN, RESP. All state transitions occur on `clk` edges.
- **IDLE**
  - Combinational grant: if exactly one `req_valid_k` is high, that requester is granted.
  - If both are high, the requester not equal to `last_grant` is granted. `last_grant` resets to 1, so requester 0 wins the first tie.
  - `req_ready_k` is high only for the granted requester, and only in IDLE.
  - On handshake: latch all operands into `core_*` registers; latch `req_data` into both `core_plaintext` and `core_ciphertext`; record grant index `g`; set `last_grant <= g`; clear the cycle counter; go to RUN.
- **RUN**
  - `core_start = 1`. Operands are held stable. The cycle counter increments every cycle.
  - When `core_ready_in = 1`: capture `rsp_data <= core_encrypt ? core_ciphertext_in : core_plaintext_in`, `rsp_tag <= core_tag_in`, `rsp_err <= 0`; go to DRAIN.
  - When the counter reaches `TIMEOUT_CYCLES - 1` without `core_ready_in`: `rsp_data <= 0`, `rsp_tag <= 0`, `rsp_err <= 1`; go to DRAIN.
  - If `core_ready_in` and the timeout occur on the same cycle, `core_ready_in` wins.
- **DRAIN**: `core_start = 0` for exactly 2 cycles, which returns the core to its waiting phase and clears its `ready_out`. Then go to RESP.
- **RESP**
  - `rsp_valid_g = 1`; the other `rsp_valid` stays 0. `rsp_data`, `rsp_tag`, `rsp_err` are held stable.
  - On `rsp_ready_g = 1`: go to IDLE. `rsp_data`, `rsp_tag`, `rsp_err` retain their values until the next capture.
- Requests arriving outside IDLE are ignored: ready stays 0 and the requester must hold `valid`.
- `core_start` is never high in IDLE, DRAIN or RESP.

## Timing
- Reset values: state IDLE; every output 0, including all `core_*`, `rsp_*` and `busy`; `last_grant = 1`; counter 0.
- `req_ready_k` is combinational from `req_valid_*` and state; no other output is combinational.
- Handshake in cycle T → `core_start = 1` from T+1.
- `core_ready_in` seen in cycle R → `core_start = 0` at R+1 and R+2 → `rsp_valid_g = 1` at R+3.
- Accept-to-response latency is (core job cycles) + 3, plus backpressure.
- Back-to-back: `rsp_ready` in cycle S → IDLE at S+1. Earliest next handshake is S+1, so `core_start` is low for at least 3 cycles between jobs.
- `rst` asserted in any state → IDLE at the next edge and `core_start = 0`. In-flight job and pending response are dropped with no `rsp_valid` pulse. The core's own reset is the system's responsibility.
- Counter is 16 bits, saturating, and never wraps.

## Configuration
- `ACORN_SCHED_TIMEOUT_EN` defined: the watchdog counter and the RUN timeout exit are compiled in, and `rsp_err` behaves as above.
- Not defined: the counter logic is removed, RUN exits only on `core_ready_in`, `rsp_err` is tied 0, and `TIMEOUT_CYCLES` is ignored.

## Test plan
- **Single encrypt**: req0, encrypt=1, key=iv=0, data=`128'h1`; core model raises ready 3330 cycles after start with ct=`128'hA5…` and tag=`128'h5A…` → rsp_valid_0 3 cycles later with those values, `rsp_err = 0`, rsp_valid_1 stays 0.
- **Simultaneous requests from reset**: req0 and req1 both valid → req0 granted first, req1 granted in the first IDLE after req0's response. `core_start` is low for ≥3 cycles between the jobs.
- **Fairness**: req0 held valid continuously, req1 valid → grants alternate 0,1,0,1 across 4 jobs.
- **Decrypt routing**: req1, encrypt=0, core_plaintext_in=`128'hDEAD`, core_ciphertext_in=`128'hBEEF` → `rsp_data = 128'hDEAD` on rsp_valid_1.
- **Backpressure**: rsp_ready_0 low for 50 cycles in RESP → rsp_valid_0, `rsp_data`, `rsp_tag` constant for all 50 cycles; req1 is not accepted until after the response handshake.
- **Timeout and reset** (macro defined, `TIMEOUT_CYCLES=100`):
  - core_ready_in held 0 → exactly 100 RUN cycles, then 2 DRAIN cycles, then `rsp_err = 1` with `rsp_data = rsp_tag = 0`.
  - Separately, rst pulsed at RUN cycle 10 → IDLE and `core_start = 0` on the next edge, with no rsp_valid.
